// File: rtl/handshake_match_pkg.sv
// Shared types and defaults for the constant-match receiver.
// FIFO occupancy encoding plus parameter defaults.
package handshake_match_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } fifo_state_e;

  localparam int          DEF_DATA_WIDTH  = 36;
  localparam logic [35:0] DEF_CONST_VALUE = 36'h47D83BD3B;
  localparam int          DEF_COUNT_WIDTH = 16;

endpackage

// File: rtl/handshake_fifo2.sv
// Two-entry elastic valid/ready buffer.
// Ready is derived from occupancy only, never from dn_ready.
module handshake_fifo2
  import handshake_match_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] up_data,
  input  logic         up_valid,
  output logic         up_ready,
  output logic [W-1:0] dn_data,
  output logic         dn_valid,
  input  logic         dn_ready
);

  fifo_state_e  state_q, state_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic         push, pop;

  assign up_ready = !rst && (state_q != TWO);
  assign dn_valid = (state_q != EMPTY);
  assign dn_data  = head_q;
  assign push     = up_valid && up_ready;
  assign pop      = dn_valid && dn_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          head_d  = up_data;
          state_d = ONE;
        end
      end
      ONE: begin
        if (push && !pop) begin
          tail_d  = up_data;
          state_d = TWO;
        end else if (!push && pop) begin
          state_d = EMPTY;
        end else if (push && pop) begin
          head_d  = up_data;
        end
      end
      TWO: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

endmodule

// File: rtl/handshake_constant_match.sv
// Compares each accepted token with a constant and emits a 1-bit
// condition token; saturating counters and sticky error for debug.
module handshake_constant_match
  import handshake_match_pkg::*;
#(
  parameter int                    DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] CONST_VALUE = DEF_CONST_VALUE,
  parameter int                    COUNT_WIDTH = DEF_COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  ins,
  input  logic                   ins_valid,
  output logic                   ins_ready,
  output logic                   outs,
  output logic                   outs_valid,
  input  logic                   outs_ready,
  output logic [COUNT_WIDTH-1:0] token_count,
  output logic [COUNT_WIDTH-1:0] mismatch_count,
  output logic                   error
);

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  logic match;
  logic in_xfer;

  assign match   = (ins == CONST_VALUE);
  assign in_xfer = ins_valid && ins_ready;

  handshake_fifo2 #(
    .W(1)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .up_data  (match),
    .up_valid (ins_valid),
    .up_ready (ins_ready),
    .dn_data  (outs),
    .dn_valid (outs_valid),
    .dn_ready (outs_ready)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      token_count    <= '0;
      mismatch_count <= '0;
      error          <= 1'b0;
    end else if (in_xfer) begin
      if (token_count != CNT_MAX)
        token_count <= token_count + 1'b1;
      if (!match) begin
        error <= 1'b1;
        if (mismatch_count != CNT_MAX)
          mismatch_count <= mismatch_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_handshake_constant_match.sv
// Scoreboard bench: monitor pops expected condition tokens,
// directed phases cover latency, backpressure, reset and saturation.
module tb_handshake_constant_match;

  localparam logic [35:0] C = 36'h47D83BD3B;

  logic        clk = 0;
  logic        rst = 1;
  logic [35:0] ins = '0;
  logic        ins_valid = 0;
  logic        ins_ready;
  logic        outs;
  logic        outs_valid;
  logic        outs_ready = 0;
  logic [15:0] token_count;
  logic [15:0] mismatch_count;
  logic        error;

  logic [35:0] ins2 = '0;
  logic        ins_valid2 = 0;
  logic        ins_ready2;
  logic        outs2;
  logic        outs_valid2;
  logic [3:0]  token_count2;
  logic [3:0]  mismatch_count2;
  logic        error2;

  int n_vec = 0;
  int n_bad = 0;

  bit exp_q[$];
  int m_tok = 0;
  int m_mis = 0;
  bit m_err = 0;

  always #5 clk = ~clk;

  handshake_constant_match dut (
    .clk            (clk),
    .rst            (rst),
    .ins            (ins),
    .ins_valid      (ins_valid),
    .ins_ready      (ins_ready),
    .outs           (outs),
    .outs_valid     (outs_valid),
    .outs_ready     (outs_ready),
    .token_count    (token_count),
    .mismatch_count (mismatch_count),
    .error          (error)
  );

  handshake_constant_match #(
    .COUNT_WIDTH(4)
  ) dut_sat (
    .clk            (clk),
    .rst            (rst),
    .ins            (ins2),
    .ins_valid      (ins_valid2),
    .ins_ready      (ins_ready2),
    .outs           (outs2),
    .outs_valid     (outs_valid2),
    .outs_ready     (1'b1),
    .token_count    (token_count2),
    .mismatch_count (mismatch_count2),
    .error          (error2)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat16(input int n);
    return (n > 65535) ? 65535 : n;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [35:0] rnd36();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[35:0];
  endfunction

  // Reference model: every accepted token yields (data == C), in order.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_tok = 0;
      m_mis = 0;
      m_err = 0;
    end else begin
      chk("token_count", token_count, sat16(m_tok));
      chk("mismatch_count", mismatch_count, sat16(m_mis));
      chk("error", error, m_err);
      if (outs_valid && outs_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_token", 1, 0);
        end else begin
          chk("outs", outs, exp_q.pop_front());
        end
      end
      if (ins_valid && ins_ready) begin
        bit e;
        e = (ins == C);
        exp_q.push_back(e);
        m_tok++;
        if (!e) begin
          m_mis++;
          m_err = 1;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int xf;
    int cyc;
    logic [15:0] tc0;

    // Reset state
    step();
    step();
    chk("rst_ins_ready", ins_ready, 0);
    chk("rst_outs_valid", outs_valid, 0);
    chk("rst_outs", outs, 0);
    chk("rst_tok", token_count, 0);
    chk("rst_err", error, 0);
    rst = 0;
    #1;
    chk("rel_ins_ready", ins_ready, 1);

    // Match / mismatch / match stream with latency 1
    outs_ready = 1;
    step();
    ins = C;
    ins_valid = 1;
    step();
    chk("lat_v1", outs_valid, 1);
    chk("lat_o1", outs, 1);
    ins = '0;
    step();
    chk("lat_v2", outs_valid, 1);
    chk("lat_o2", outs, 0);
    ins = C;
    step();
    chk("lat_v3", outs_valid, 1);
    chk("lat_o3", outs, 1);
    ins_valid = 0;
    step();
    chk("s1_empty", outs_valid, 0);
    chk("s1_tok", token_count, 3);
    chk("s1_mis", mismatch_count, 1);
    chk("s1_err", error, 1);

    // Backpressure: two tokens absorbed, then stall
    outs_ready = 0;
    ins_valid = 1;
    xf = 0;
    for (int i = 0; i < 6; i++) begin
      ins = (i == 0) ? C : rnd36();
      if (ins_ready) xf++;
      step();
      if (i == 1) chk("bp_full_next", ins_ready, 0);
    end
    chk("bp_xfers", xf, 2);
    ins_valid = 0;
    outs_ready = 1;
    #1;
    chk("bp_ready_same", ins_ready, 0);
    chk("bp_head", outs, 1);
    step();
    chk("bp_ready_next", ins_ready, 1);
    chk("bp_second_v", outs_valid, 1);
    step();
    chk("bp_drained", outs_valid, 0);

    // Reset with two results buffered
    outs_ready = 0;
    ins_valid = 1;
    ins = C;
    step();
    step();
    step();
    chk("pre_rst_full", ins_ready, 0);
    rst = 1;
    #1;
    chk("mid_rst_valid", outs_valid, 0);
    chk("mid_rst_tok", token_count, 0);
    chk("mid_rst_mis", mismatch_count, 0);
    chk("mid_rst_err", error, 0);
    chk("mid_rst_ready", ins_ready, 0);
    ins_valid = 0;
    step();
    chk("in_rst_valid", outs_valid, 0);
    rst = 0;
    step();
    chk("post_rst_quiet", outs_valid, 0);
    outs_ready = 1;
    ins = C;
    ins_valid = 1;
    step();
    ins_valid = 0;
    chk("post_rst_v", outs_valid, 1);
    chk("post_rst_o", outs, 1);
    step();

    // Idle data toggling without valid
    tc0 = token_count;
    for (int i = 0; i < 10; i++) begin
      ins = rnd36();
      step();
      chk("idle_valid", outs_valid, 0);
    end
    chk("idle_tok", token_count, tc0);

    // Saturation on the 4-bit instance
    ins2 = 36'h1;
    ins_valid2 = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 14) chk("sat_tok15", token_count2, 15);
    end
    ins_valid2 = 0;
    step();
    chk("sat_tok", token_count2, 15);
    chk("sat_mis", mismatch_count2, 15);
    chk("sat_err", error2, 1);

    // Random traffic, 1000 tokens from a fresh reset
    rst = 1;
    step();
    rst = 0;
    step();
    xf = 0;
    cyc = 0;
    while (m_tok < 1000 && cyc < 20000) begin
      ins_valid = $urandom_range(1, 0);
      ins = ($urandom_range(9, 0) == 0) ? C : rnd36();
      outs_ready = $urandom_range(1, 0);
      step();
      cyc++;
    end
    chk("rand_timeout", cyc < 20000, 1);
    ins_valid = 0;
    outs_ready = 1;
    step();
    step();
    step();
    chk("rand_tok", token_count, 1000);
    chk("rand_mis", mismatch_count, m_mis);
    chk("rand_loss", exp_q.size(), 0);
    chk("rand_empty", outs_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/handshake_constant_match.md
# handshake_constant_match

Dataflow receiver that consumes a data token stream, compares every accepted token against a compile-time constant, and emits a 1-bit equality token per input token through a two-entry elastic buffer. It is the consumer-side counterpart of the constant-token generators: it sits downstream of a constant source or a datapath that must reproduce a constant, and converts data tokens into condition tokens for branch/merge units. Saturating token and mismatch counters plus a sticky error flag provide in-circuit observability.

## Interface
- DATA_WIDTH, 36, width of `ins` tokens
- CONST_VALUE, 36'h47D83BD3B, expected value (DATA_WIDTH bits)
- COUNT_WIDTH, 16, width of both counters
- clk  input  1  rising-edge clock
- rst  input  1  reset; asynchronous, active-high
- ins  input  DATA_WIDTH  input token data
- ins_valid  input  1  input token present
- ins_ready  output  1  block can accept a token
- outs  output  1  equality result: 1 = token equalled CONST_VALUE
- outs_valid  output  1  result token present
- outs_ready  input  1  downstream accepts result
- token_count  output  COUNT_WIDTH  accepted input tokens, saturating
- mismatch_count  output  COUNT_WIDTH  accepted tokens != CONST_VALUE, saturating
- error  output  1  sticky: set on first mismatch, cleared only by rst

## Operation
- Input transfer when `ins_valid && ins_ready`; output transfer when `outs_valid && outs_ready`.
- Comparison is full-width, bitwise equality of `ins` against CONST_VALUE, evaluated combinationally at the input transfer; only the 1-bit result is stored.
- Result storage: two-entry FIFO, states EMPTY, ONE, TWO.
  - EMPTY: in -> ONE; no in -> EMPTY.
  - ONE: in only -> TWO; out only -> EMPTY; in and out -> ONE (entry replaced, order preserved).
  - TWO: out -> ONE; in impossible (`ins_ready`=0).
- `ins_ready` = (state != TWO), driven from state register only; no combinational path from `outs_ready` to `ins_ready`.
- `outs_valid` = (state != EMPTY); `outs` = head entry; head stable while `outs_valid && !outs_ready`.
- `token_count` increments on each input transfer; `mismatch_count` increments on each input transfer with result 0; both hold at all-ones (no wrap).
- `error` sets in the cycle after the first mismatching input transfer.
- Data on `ins` while no transfer is ignored (no compare side effects).

## Timing
- Reset (async assert, sync release): state EMPTY, `outs_valid`=0, `outs`=0, counters 0, `error`=0; `ins_ready`=0 while rst is high, 1 in first cycle after release.
- Reset mid-operation discards buffered results immediately; no token emitted afterwards until a new input transfer.
- Latency: input transfer in cycle N -> result visible on `outs` with `outs_valid`=1 in cycle N+1.
- Throughput: one token per cycle sustained when `outs_ready`=1 continuously.
- Backpressure: with `outs_ready`=0, exactly two tokens accepted, then `ins_ready`=0 from the cycle after the second transfer.
- Full with simultaneous output: in TWO, an output transfer in cycle N gives `ins_ready`=1 in N+1 (not N).
- Counters/error update in the cycle after the transfer (registered).

## Structure
- Package `handshake_match_pkg`: FIFO state enum (EMPTY/ONE/TWO), default CONST_VALUE and COUNT_WIDTH constants.
- Sub-module `handshake_fifo2`: generic two-entry valid/ready FIFO parameterised on width (used here with width 1); comparator and counters stay in the top module.

## Test plan
- Reset then stream 0x47D83BD3B, 0x0, 0x47D83BD3B with `outs_ready`=1 -> `outs` 1,0,1 in cycles N+1..N+3; `token_count`=3, `mismatch_count`=1, `error`=1.
- `outs_ready`=0, `ins_valid`=1 constant -> exactly 2 transfers, `ins_ready`=0 thereafter; release `outs_ready` -> results drained in order, `ins_ready`=1 one cycle after first output transfer.
- Random valid/ready (50%/50%), 1000 tokens, 10% matching -> scoreboard order exact, no loss/duplication, `token_count`=1000, `mismatch_count` equals mismatch total.
- COUNT_WIDTH=4, 20 mismatching tokens -> both counters stop at 15.
- Assert rst with two results buffered -> `outs_valid`=0 same cycle, counters 0, `error`=0; post-release first token emitted correctly.
- `ins` toggling with `ins_valid`=0 -> no output tokens, counters unchanged.
